// File: rtl/answer_entry.sv
// rtl/answer_entry.sv - keypad answer entry buffer feeding the checker; ENTRY_TIMEOUT_EN adds idle discard
module answer_entry #(
    parameter int DIGITS = 6
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 50000000
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  round_start,
    input  logic                  key_valid,
    input  logic [4:0]            key_code,
    output logic [4*DIGITS-1:0]   check_out,
    output logic [4*DIGITS-1:0]   entry_disp,
    output logic [2:0]            digit_cnt,
    output logic                  submit_pulse,
    output logic                  key_err
);
    localparam int W = 4 * DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(DIGITS);

    typedef enum logic [1:0] {IDLE, ENTRY, SUBMIT} state_t;

    state_t         state_q, state_n;
    logic [W-1:0]   entry_q, entry_n;
    logic [W-1:0]   chk_q, chk_n;
    logic [2:0]     cnt_q, cnt_n;
    logic           submit_n, err_n;

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT_CYC - 1);
    logic [25:0] idle_q, idle_n;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            chk_q        <= '0;
            cnt_q        <= '0;
            submit_pulse <= 1'b0;
            key_err      <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_n;
            entry_q      <= entry_n;
            chk_q        <= chk_n;
            cnt_q        <= cnt_n;
            submit_pulse <= submit_n;
            key_err      <= err_n;
`ifdef ENTRY_TIMEOUT_EN
            idle_q       <= idle_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        entry_n  = entry_q;
        chk_n    = chk_q;
        cnt_n    = cnt_q;
        submit_n = 1'b0;
        err_n    = 1'b0;
        if (round_start) begin
            state_n = IDLE;
            entry_n = '0;
            chk_n   = '0;
            cnt_n   = '0;
        end else if (key_valid) begin
            case (key_code)
                5'h00, 5'h01, 5'h02, 5'h03, 5'h04,
                5'h05, 5'h06, 5'h07, 5'h08, 5'h09: begin
                    if (cnt_q == MAX_CNT) begin
                        err_n = 1'b1;
                    end else begin
                        if (state_q == SUBMIT) begin
                            entry_n = {{(W-4){1'b0}}, key_code[3:0]};
                            cnt_n   = 3'd1;
                        end else begin
                            entry_n = {entry_q[W-5:0], key_code[3:0]};
                            cnt_n   = cnt_q + 3'd1;
                        end
                        state_n = ENTRY;
                    end
                end
                5'h0A: begin
                    state_n = IDLE;
                    entry_n = '0;
                    chk_n   = '0;
                    cnt_n   = '0;
                end
                5'h0B: begin
                    if (cnt_q == 3'd0) begin
                        err_n = 1'b1;
                    end else begin
                        entry_n = entry_q >> 4;
                        cnt_n   = cnt_q - 3'd1;
                        if (cnt_q == 3'd1)
                            state_n = (chk_q == '0) ? IDLE : SUBMIT;
                    end
                end
                5'h0C: begin
                    // an all-zero answer would read as "no answer" at the checker
                    if (cnt_q == 3'd0 || entry_q == '0) begin
                        err_n = 1'b1;
                    end else begin
                        chk_n    = entry_q;
                        submit_n = 1'b1;
                        entry_n  = '0;
                        cnt_n    = '0;
                        state_n  = SUBMIT;
                    end
                end
                default: err_n = 1'b1;
            endcase
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (cnt_q != 3'd0 && idle_q == IDLE_LAST) begin
            entry_n = '0;
            cnt_n   = '0;
            state_n = (chk_q == '0) ? IDLE : SUBMIT;
        end
`endif
    end

`ifdef ENTRY_TIMEOUT_EN
    always_comb begin
        idle_n = idle_q + 26'd1;
        if (round_start || key_valid || cnt_q == 3'd0 || idle_q == IDLE_LAST)
            idle_n = '0;
    end
`endif

    assign check_out  = chk_q;
    assign entry_disp = entry_q;
    assign digit_cnt  = cnt_q;
endmodule

// File: tb/tb_answer_entry.sv
// tb/tb_answer_entry.sv - directed checks of answer_entry key handling
module tb_answer_entry;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        round_start = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'h00;
    logic [23:0] check_out, entry_disp;
    logic [2:0]  digit_cnt;
    logic        submit_pulse, key_err;
    int          total = 0;
    int          bad = 0;

    always #5 CLK = ~CLK;

`ifdef ENTRY_TIMEOUT_EN
    answer_entry #(.DIGITS(6), .TIMEOUT_CYC(16)) dut (
`else
    answer_entry #(.DIGITS(6)) dut (
`endif
        .CLK(CLK), .RST(RST), .round_start(round_start),
        .key_valid(key_valid), .key_code(key_code),
        .check_out(check_out), .entry_disp(entry_disp), .digit_cnt(digit_cnt),
        .submit_pulse(submit_pulse), .key_err(key_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic key(input logic [4:0] code);
        @(negedge CLK);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge CLK);
        key_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic outs(input string tag, input logic [23:0] c, input logic [23:0] d,
                        input logic [2:0] n, input logic s, input logic e);
        check({tag, ".check_out"}, 32'(check_out), 32'(c));
        check({tag, ".entry_disp"}, 32'(entry_disp), 32'(d));
        check({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(n));
        check({tag, ".submit"}, 32'(submit_pulse), 32'(s));
        check({tag, ".key_err"}, 32'(key_err), 32'(e));
    endtask

    initial begin
        tick(3);
        outs("reset", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        RST = 1'b0;

        for (int i = 1; i <= 6; i++) key(5'(i));
        outs("six_digits", 24'h0, 24'h123456, 3'd6, 1'b0, 1'b0);
        key(5'h0C);
        outs("enter", 24'h123456, 24'h0, 3'd0, 1'b1, 1'b0);
        tick(1);
        check("submit_one_cycle", 32'(submit_pulse), 32'd0);

        key(5'h0A);
        outs("clear", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) key(5'(i));
        key(5'h07);
        outs("overflow", 24'h0, 24'h123456, 3'd6, 1'b0, 1'b1);
        tick(1);
        check("err_one_cycle", 32'(key_err), 32'd0);
        key(5'h0B);
        outs("bksp1", 24'h0, 24'h012345, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) key(5'h0B);
        outs("bksp6", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        key(5'h0B);
        outs("bksp_empty", 24'h0, 24'h0, 3'd0, 1'b0, 1'b1);

        key(5'h00);
        key(5'h00);
        check("zeros_cnt", 32'(digit_cnt), 32'd2);
        key(5'h0C);
        outs("enter_zero", 24'h0, 24'h0, 3'd2, 1'b0, 1'b1);
        key(5'h0A);
        key(5'h0C);
        outs("enter_empty", 24'h0, 24'h0, 3'd0, 1'b0, 1'b1);

        key(5'h03);
        key(5'h05);
        key(5'h0C);
        outs("enter_35", 24'h000035, 24'h0, 3'd0, 1'b1, 1'b0);
        key(5'h09);
        outs("fresh_after_submit", 24'h000035, 24'h000009, 3'd1, 1'b0, 1'b0);
        key(5'h1F);
        outs("invalid", 24'h000035, 24'h000009, 3'd1, 1'b0, 1'b1);
        key(5'h0D);
        outs("invalid_0d", 24'h000035, 24'h000009, 3'd1, 1'b0, 1'b1);
        key(5'h0B);
        outs("bksp_to_submit", 24'h000035, 24'h0, 3'd0, 1'b0, 1'b0);
        key(5'h0A);
        outs("clear_answer", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);

        key(5'h01);
        key(5'h02);
        key(5'h0C);
        key(5'h07);
        @(negedge CLK);
        round_start = 1'b1;
        key_valid   = 1'b1;
        key_code    = 5'h04;
        @(negedge CLK);
        round_start = 1'b0;
        key_valid   = 1'b0;
        outs("round_start", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        key(5'h05);
        key(5'h06);
        key(5'h0C);
        key(5'h08);
        check("pre_rst_disp", 32'(entry_disp), 32'h8);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        outs("rst_mid", 24'h0, 24'h0, 3'd0, 1'b0, 1'b0);

`ifdef ENTRY_TIMEOUT_EN
        key(5'h07);
        key(5'h0C);
        key(5'h08);
        tick(15);
        outs("to_hold15", 24'h7, 24'h8, 3'd1, 1'b0, 1'b0);
        tick(1);
        outs("to_fire", 24'h7, 24'h0, 3'd0, 1'b0, 1'b0);
        key(5'h08);
        tick(14);
        key(5'h09);
        tick(15);
        outs("to_restart", 24'h7, 24'h89, 3'd2, 1'b0, 1'b0);
        tick(1);
        outs("to_fire2", 24'h7, 24'h0, 3'd0, 1'b0, 1'b0);
        key(5'h01);
        outs("to_after_submit", 24'h7, 24'h1, 3'd1, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
